// File: rtl/sram_ctrl_param_if.sv
// CPU-side request/response bus of the SRAM controller: a request is held
// until ready, and read_data carries the registered result of the last read.
interface sram_ctrl_param_if #(
  parameter int DATA_W = 32
) ();
  logic              wr_en;
  logic              rd_en;
  logic [31:0]       address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_ctrl_param.sv
// Asynchronous SRAM controller: splits a DATA_W-bit CPU access into BEATS
// SRAM_DW-bit beats, then settles for WAIT_CYC cycles before a one-cycle ready.
module sram_ctrl_param #(
  parameter int DATA_W    = 32,
  parameter int SRAM_DW   = 16,
  parameter int SRAM_AW   = 18,
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYC  = 4
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_param_if.slave   bus,
  inout  wire  [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int BEATS   = DATA_W / SRAM_DW;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_SH = $clog2(BEATS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  localparam logic [31:0]       BASE      = 32'(BASE_ADDR);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [3:0]        WAIT_LAST = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  if ((DATA_W % SRAM_DW) != 0 || (DATA_W % 8) != 0 ||
      !(BEATS == 1 || BEATS == 2 || BEATS == 4 || BEATS == 8)) begin : g_bad_width
    $error("sram_ctrl_param: DATA_W/SRAM_DW must be a power of two between 1 and 8");
  end
  if (WAIT_CYC < 0 || WAIT_CYC > 15 || SRAM_AW > 32) begin : g_bad_param
    $error("sram_ctrl_param: WAIT_CYC must be 0..15 and SRAM_AW at most 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ADDR,
    READ_CAP,
    WAIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [3:0]          wait_q, wait_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                dq_oe_q, dq_oe_d;
  logic [SRAM_DW-1:0]  dq_out_q, dq_out_d;
  logic                last_beat;

  assign last_beat = (beat_q == BEAT_LAST);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave a latch behind.
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;

    unique case (state_q)
      IDLE: begin
        if (bus.wr_en || bus.rd_en) begin
          state_d = bus.wr_en ? WRITE : READ_ADDR;
          beat_d  = '0;
          addr_d  = bus.address;
          wdata_d = bus.write_data;
        end
      end
      WRITE: begin
        if (last_beat) begin
          state_d = (WAIT_CYC == 0) ? DONE : WAIT;
          wait_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      READ_ADDR: state_d = READ_CAP;
      READ_CAP: begin
        // The address has been stable for a full cycle, so the bus is settled here.
        read_data_d[beat_q*SRAM_DW +: SRAM_DW] = SRAM_DQ;
        if (last_beat) begin
          state_d = (WAIT_CYC == 0) ? DONE : WAIT;
          wait_d  = '0;
        end else begin
          state_d = READ_ADDR;
          beat_d  = beat_q + BEAT_W'(1);
        end
      end
      WAIT: begin
        if (wait_q == WAIT_LAST) state_d = DONE;
        else                     wait_d  = wait_q + 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM pins are decoded from the next state so they leave a flop cleanly.
    sram_addr_d = '0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b0;
    dq_oe_d     = 1'b0;
    dq_out_d    = '0;
    if (state_d inside {WRITE, READ_ADDR, READ_CAP}) begin
      sram_addr_d = SRAM_AW'((((addr_d - BASE) >> BYTE_SH) << BEAT_SH) | 32'(beat_d));
    end
    if (state_d == WRITE) begin
      we_n_d   = 1'b0;
      oe_n_d   = 1'b1;
      dq_oe_d  = 1'b1;
      dq_out_d = wdata_d[beat_d*SRAM_DW +: SRAM_DW];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  // In IDLE, ready drops as soon as a request shows up, before it is accepted.
  assign bus.ready     = (state_q == IDLE) ? ~(bus.wr_en | bus.rd_en) : (state_q == DONE);
  assign bus.read_data = read_data_q;

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 'z;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Scoreboard bench for sram_ctrl_param: three configurations (32-bit/wait 4,
// 64-bit/wait 4, 32-bit/wait 0), each with its own SRAM model and monitor.
module tb_sram_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  logic model_en = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl_param_if #(.DATA_W(32)) bus0 ();
  sram_ctrl_param_if #(.DATA_W(64)) bus1 ();
  sram_ctrl_param_if #(.DATA_W(32)) bus2 ();

  wire  [15:0] dq0, dq1, dq2;
  logic [17:0] sa0, sa1, sa2;
  logic we0, oe0, ce0, ub0, lb0;
  logic we1, oe1, ce1, ub1, lb1;
  logic we2, oe2, ce2, ub2, lb2;

  sram_ctrl_param #(.DATA_W(32), .WAIT_CYC(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .SRAM_DQ(dq0), .SRAM_ADDR(sa0),
    .SRAM_WE_N(we0), .SRAM_OE_N(oe0), .SRAM_CE_N(ce0), .SRAM_UB_N(ub0), .SRAM_LB_N(lb0)
  );
  sram_ctrl_param #(.DATA_W(64), .WAIT_CYC(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
    .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1)
  );
  sram_ctrl_param #(.DATA_W(32), .WAIT_CYC(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .SRAM_DQ(dq2), .SRAM_ADDR(sa2),
    .SRAM_WE_N(we2), .SRAM_OE_N(oe2), .SRAM_CE_N(ce2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2)
  );

  // Asynchronous SRAM models: drive DQ while output-enabled, store on WE_N low.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  assign dq0 = (model_en && !oe0 && we0) ? mem0[sa0[7:0]] : 16'bz;
  assign dq1 = (model_en && !oe1 && we1) ? mem1[sa1[7:0]] : 16'bz;
  assign dq2 = (model_en && !oe2 && we2) ? mem2[sa2[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (!we0) mem0[sa0[7:0]] <= dq0;
    if (!we1) mem1[sa1[7:0]] <= dq1;
    if (!we2) mem2[sa2[7:0]] <= dq2;
  end

  typedef enum int {EV_NONE, EV_BEAT, EV_DONE} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] addr;
    logic [63:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q [3][$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int d, input ev_kind_e k, input logic [31:0] a,
                      input logic [63:0] v, input int c);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = v;
    e.cyc  = c;
    exp_q[d].push_back(e);
  endtask

  task automatic beat(input int d, input logic [31:0] a, input logic [15:0] v);
    push(d, EV_BEAT, a, {48'd0, v}, 0);
  endtask

  function automatic ev_t pop(input int d);
    ev_t e;
    e.kind = EV_NONE;
    e.addr = '0;
    e.data = '0;
    e.cyc  = 0;
    if (exp_q[d].size() != 0) e = exp_q[d].pop_front();
    return e;
  endfunction

  task automatic mon(input int d, input logic we_n, input logic [17:0] sa, input logic [15:0] dq,
                     input logic rdy, input logic req, input logic [63:0] rdata);
    ev_t e;
    if (!we_n) begin
      e = pop(d);
      check($sformatf("dut%0d event kind (beat)", d), 64'(EV_BEAT), 64'(e.kind));
      if (e.kind == EV_BEAT) begin
        check($sformatf("dut%0d beat SRAM_ADDR", d), 64'(sa), 64'(e.addr[17:0]));
        check($sformatf("dut%0d beat SRAM_DQ", d), 64'(dq), e.data);
      end
    end
    // ready together with a held request can only be the DONE cycle.
    if (rdy && req) begin
      e = pop(d);
      check($sformatf("dut%0d event kind (done)", d), 64'(EV_DONE), 64'(e.kind));
      if (e.kind == EV_DONE) begin
        check($sformatf("dut%0d read_data at done", d), rdata, e.data);
        check($sformatf("dut%0d done cycle", d), 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, we0, sa0, dq0, bus0.ready, bus0.wr_en | bus0.rd_en, {32'd0, bus0.read_data});
      mon(1, we1, sa1, dq1, bus1.ready, bus1.wr_en | bus1.rd_en, bus1.read_data);
      mon(2, we2, sa2, dq2, bus2.ready, bus2.wr_en | bus2.rd_en, {32'd0, bus2.read_data});
    end
  end

  task automatic drive(input int d, input logic wr, input logic rd, input logic [31:0] a,
                       input logic [63:0] wd);
    case (d)
      0: begin bus0.wr_en = wr; bus0.rd_en = rd; bus0.address = a; bus0.write_data = wd[31:0]; end
      1: begin bus1.wr_en = wr; bus1.rd_en = rd; bus1.address = a; bus1.write_data = wd; end
      default: begin bus2.wr_en = wr; bus2.rd_en = rd; bus2.address = a; bus2.write_data = wd[31:0]; end
    endcase
  endtask

  function automatic logic done_now(input int d);
    case (d)
      0:       return bus0.ready && (bus0.wr_en || bus0.rd_en);
      1:       return bus1.ready && (bus1.wr_en || bus1.rd_en);
      default: return bus2.ready && (bus2.wr_en || bus2.rd_en);
    endcase
  endfunction

  task automatic wait_done(input int d, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = done_now(d);
    end
    if (!seen) check($sformatf("dut%0d done within %0d cycles", d, budget), 64'(seen), 64'd1);
  endtask

  // One transaction; address and payload move after acceptance to prove latching.
  task automatic txn(input int d, input logic wr, input logic rd, input logic [31:0] a,
                     input logic [63:0] wd, input logic [63:0] exp_rd, input int lat);
    @(posedge clk); #1;
    drive(d, wr, rd, a, wd);
    push(d, EV_DONE, '0, exp_rd, cyc + lat);
    @(posedge clk); #1;
    drive(d, wr, rd, a ^ 32'h00F0_0F3C, ~wd);
    wait_done(d, lat + 8);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b0, a, wd);
  endtask

  task automatic check_idle0(input string tag);
    model_en = 1'b0;
    #1;
    check({tag, " ready"}, 64'(bus0.ready), 64'd1);
    check({tag, " read_data"}, 64'(bus0.read_data), 64'd0);
    check({tag, " SRAM_WE_N"}, 64'(we0), 64'd1);
    check({tag, " SRAM_ADDR"}, 64'(sa0), 64'd0);
    check({tag, " SRAM_DQ"}, 64'(dq0), {48'd0, 16'hzzzz});
    check({tag, " OE/CE/UB/LB"}, 64'({oe0, ce0, ub0, lb0}), 64'd0);
    model_en = 1'b1;
  endtask

  initial begin
    int n0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'd0, 64'd0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle0("reset");
    rst = 1'b0;

    // Config 0: 32-bit, two beats, four settle cycles.
    beat(0, 0, 16'hBEEF); beat(0, 1, 16'hDEAD);
    txn(0, 1'b1, 1'b0, 32'd1024, 64'hDEADBEEF, 64'd0, 7);
    txn(0, 1'b0, 1'b1, 32'd1024, 64'd0, 64'hDEADBEEF, 9);
    beat(0, 2, 16'h5678); beat(0, 3, 16'h1234);
    txn(0, 1'b1, 1'b1, 32'd1028, 64'h12345678, 64'hDEADBEEF, 7);
    txn(0, 1'b0, 1'b1, 32'd1028, 64'd0, 64'h12345678, 9);
    beat(0, 4, 16'h5A5A); beat(0, 5, 16'hA5A5);
    txn(0, 1'b1, 1'b0, 32'd1035, 64'hA5A55A5A, 64'h12345678, 7);
    beat(0, 32'h3FFFE, 16'hF00D); beat(0, 32'h3FFFF, 16'hCAFE);
    txn(0, 1'b1, 1'b0, 32'd1020, 64'hCAFEF00D, 64'h12345678, 7);
    txn(0, 1'b0, 1'b1, 32'd1020, 64'd0, 64'hCAFEF00D, 9);
    txn(0, 1'b0, 1'b1, 32'd1033, 64'd0, 64'hA5A55A5A, 9);

    // A read held through DONE starts a second read after one idle cycle.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1024, 64'd0);
    push(0, EV_DONE, '0, 64'hDEADBEEF, cyc + 9);
    push(0, EV_DONE, '0, 64'hDEADBEEF, cyc + 19);
    wait_done(0, 20);
    wait_done(0, 20);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd1024, 64'd0);

    // Reset in the middle of a read's settle phase aborts it.
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd1028, 64'd0);
    n0 = cyc;
    while (cyc < n0 + 6) begin @(posedge clk); #1; end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd1028, 64'd0);
    @(posedge clk);
    check_idle0("abort");
    rst = 1'b0;
    repeat (12) @(posedge clk);
    check_idle0("after abort");

    // Config 1: 64-bit, four beats.
    beat(1, 4, 16'hCDEF); beat(1, 5, 16'h89AB); beat(1, 6, 16'h4567); beat(1, 7, 16'h0123);
    txn(1, 1'b1, 1'b0, 32'd1032, 64'h0123456789ABCDEF, 64'd0, 9);
    txn(1, 1'b0, 1'b1, 32'd1032, 64'd0, 64'h0123456789ABCDEF, 13);

    // Config 2: no settle cycles.
    beat(2, 0, 16'h9BDF); beat(2, 1, 16'h1357);
    txn(2, 1'b1, 1'b0, 32'd1024, 64'h13579BDF, 64'd0, 3);
    txn(2, 1'b0, 1'b1, 32'd1024, 64'd0, 64'h13579BDF, 5);

    repeat (5) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d events left in scoreboard", d), 64'(exp_q[d].size()), 64'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl_param.md
SRAM_CTRL_PARAM -- requirements
Module: sram_ctrl_param

Interface
REQ-001 Parameter DATA_W, 32, CPU-side data width in bits; multiple of SRAM_DW.
REQ-002 Parameter SRAM_DW, 16, SRAM data bus width.
REQ-003 Parameter SRAM_AW, 18, SRAM address width.
REQ-004 Parameter BASE_ADDR, 1024, CPU byte address mapped to SRAM location 0.
REQ-005 Parameter WAIT_CYC, 4, settle cycles after the last beat (0..15).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 wr_en  input  1  write request, held until ready.
REQ-009 rd_en  input  1  read request, held until ready.
REQ-010 address  input  32  CPU byte address.
REQ-011 write_data  input  DATA_W  write payload.
REQ-012 read_data  output  DATA_W  registered read result.
REQ-013 ready  output  1  high = no transaction pending / transaction complete.
REQ-014 SRAM_DQ  inout  SRAM_DW  SRAM data bus.
REQ-015 SRAM_ADDR  output  SRAM_AW  SRAM word address.
REQ-016 SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM controls.

Function
REQ-017 BEATS = DATA_W/SRAM_DW SHALL be a power of two (1..8); otherwise elaboration SHALL fail.
REQ-018 States SHALL be IDLE, WRITE, READ_ADDR, READ_CAP, WAIT, DONE; beat counter and wait counter are internal.
REQ-019 IDLE: wr_en=1 -> WRITE beat 0; else rd_en=1 -> READ_ADDR beat 0; else stay; wr_en has priority when both high.
REQ-020 On leaving IDLE, address and write_data SHALL be latched; later input changes SHALL not affect the transaction.
REQ-021 Word index = ((address - BASE_ADDR) mod 2^32) >> log2(DATA_W/8); SRAM_ADDR = word_index*BEATS + beat, truncated to SRAM_AW bits; address low bits ignored.
REQ-022 WRITE: one cycle per beat, SRAM_WE_N=0, SRAM_OE_N=1, SRAM_DQ driven with latched write_data[beat*SRAM_DW +: SRAM_DW]; after last beat -> WAIT.
REQ-023 READ_ADDR -> READ_CAP per beat, SRAM_ADDR held both cycles; at end of READ_CAP the beat slice of read_data SHALL load from SRAM_DQ; after last beat -> WAIT.
REQ-024 WAIT: WAIT_CYC cycles, then DONE; WAIT_CYC=0 skips WAIT.
REQ-025 DONE: ready=1 for exactly one cycle, inputs ignored, -> IDLE.
REQ-026 ready in IDLE SHALL equal ~(wr_en | rd_en) combinationally; ready=0 in WRITE, READ_ADDR, READ_CAP, WAIT.
REQ-027 Cycles from accept edge to ready: write BEATS+WAIT_CYC+1; read 2*BEATS+WAIT_CYC+1.
REQ-028 SRAM_DQ SHALL be high-Z outside WRITE; SRAM_WE_N=1 outside WRITE; SRAM_ADDR=0 in IDLE, WAIT, DONE.
REQ-029 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N SHALL be 0 always; SRAM_OE_N=0 except in WRITE.
REQ-030 read_data SHALL hold its value until the next read overwrites it; writes SHALL not modify it.
REQ-031 A request still asserted in IDLE after DONE SHALL start a new transaction.

Reset
REQ-032 rst at any edge, including mid-transaction, SHALL force IDLE, clear counters and latches, read_data=0, SRAM_WE_N=1, SRAM_DQ high-Z; the aborted transaction SHALL not complete.

Verification (DATA_W=32, WAIT_CYC=4 unless stated)
REQ-033 Write 0xDEADBEEF at 1024 -> SRAM_ADDR 0/DQ 0xBEEF then 1/0xDEAD with WE_N=0; ready high 7 cycles after accept, one cycle.
REQ-034 Read 1024 against SRAM model holding the above -> read_data 0xDEADBEEF, ready 9 cycles after accept.
REQ-035 wr_en=rd_en=1 at address 1028 -> write to SRAM_ADDR 2,3 only; no READ states entered.
REQ-036 rst asserted during WAIT of a read -> next cycle IDLE, read_data=0, DQ high-Z, WE_N=1, no ready pulse.
REQ-037 DATA_W=64: write 0x0123456789ABCDEF at 1032 -> SRAM_ADDR 4..7 with DQ 0xCDEF, 0x89AB, 0x4567, 0x0123; ready after 9 cycles.
REQ-038 WAIT_CYC=0: write at 1024 -> ready 3 cycles after accept; address changed mid-transaction -> SRAM_ADDR unaffected.
